// File: rtl/cmp63_popcount_seq_if.sv
// Handshake bundle for the sequential popcount engine: word input, result
// output, abort request and activity flag.
interface cmp63_popcount_seq_if #(
  parameter int DATA_W = 48
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count, busy
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count, busy
  );
endinterface

// File: rtl/cmp63_popcount_seq.sv
// Sequential population counter. One 6:3 compressor cell is reused once per
// 6-bit chunk of the latched word; the partial counts are summed into an
// accumulator and the total is offered on a valid/ready output.

// 6:3 compressor: counts the ones among six inputs, count = 4*CO + 2*S2 + S1.
// Built as two full adders on the inputs, then a full adder on the three
// weight-2 carries.
module cmp63_cell (
  input  logic i_a1,
  input  logic i_a2,
  input  logic i_a3,
  input  logic i_a4,
  input  logic i_a5,
  input  logic i_a6,
  output logic o_co,
  output logic o_s2,
  output logic o_s1
);
  logic w_sumA;
  logic w_carryA;
  logic w_sumB;
  logic w_carryB;
  logic w_carryM;

  assign w_sumA   = i_a1 ^ i_a2 ^ i_a3;
  assign w_carryA = (i_a1 & i_a2) | (i_a1 & i_a3) | (i_a2 & i_a3);
  assign w_sumB   = i_a4 ^ i_a5 ^ i_a6;
  assign w_carryB = (i_a4 & i_a5) | (i_a4 & i_a6) | (i_a5 & i_a6);
  assign w_carryM = w_sumA & w_sumB;

  assign o_s1 = w_sumA ^ w_sumB;
  assign o_s2 = w_carryA ^ w_carryB ^ w_carryM;
  assign o_co = (w_carryA & w_carryB) | (w_carryA & w_carryM) | (w_carryB & w_carryM);
endmodule

module cmp63_popcount_seq #(
  parameter int DATA_W = 48
) (
  input logic clk,
  input logic rst,
  cmp63_popcount_seq_if.slave bus
);
  localparam int NCHUNK = (DATA_W + 5) / 6;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PAD_W  = NCHUNK * 6;
  localparam int CHK_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [PAD_W-1:0] r_sreg;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CHK_W-1:0] r_chunk;

  logic             w_inReady;
  logic             w_outValid;
  logic             w_busy;
  logic             w_accept;
  logic             w_lastChunk;
  logic             w_co;
  logic             w_s2;
  logic             w_s1;
  logic [CNT_W-1:0] w_accSum;

  cmp63_cell u_cell (
    .i_a1 (r_sreg[0]),
    .i_a2 (r_sreg[1]),
    .i_a3 (r_sreg[2]),
    .i_a4 (r_sreg[3]),
    .i_a5 (r_sreg[4]),
    .i_a6 (r_sreg[5]),
    .o_co (w_co),
    .o_s2 (w_s2),
    .o_s1 (w_s1)
  );

  // A clear in the same cycle as a valid word suppresses acceptance.
  assign w_accept    = bus.in_valid & w_inReady & ~bus.clear;
  assign w_lastChunk = (r_state == ST_RUN) && (r_chunk == CHK_W'(NCHUNK - 1));
  assign w_accSum    = r_acc + CNT_W'({w_co, w_s2, w_s1});

  // State register; reset dominates everything.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state: one RUN cycle per chunk, DONE holds until the result is taken.
  always_comb begin
    w_nextState = r_state;
    if (bus.clear) begin
      w_nextState = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept)      w_nextState = ST_RUN;
        ST_RUN:  if (w_lastChunk)   w_nextState = ST_DONE;
        ST_DONE: if (bus.out_ready) w_nextState = ST_IDLE;
        default:                    w_nextState = ST_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decoded from the current state.
  always_comb begin
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_IDLE: w_inReady = 1'b1;
      ST_RUN:  w_busy    = 1'b1;
      ST_DONE: begin
        w_outValid = 1'b1;
        w_busy     = 1'b1;
      end
      default: w_inReady = 1'b0;
    endcase
  end

  // Datapath: latch the padded word, then shift out one chunk per RUN cycle
  // while summing compressor counts; the result register loads on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg  <= '0;
      r_acc   <= '0;
      r_chunk <= '0;
      r_count <= '0;
    end else if (bus.clear) begin
      r_acc   <= '0;
      r_chunk <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sreg  <= PAD_W'(bus.in_data);
            r_acc   <= '0;
            r_chunk <= '0;
          end
        end
        ST_RUN: begin
          r_acc  <= w_accSum;
          r_sreg <= r_sreg >> 6;
          if (w_lastChunk) begin
            r_chunk <= '0;
            r_count <= w_accSum;
          end else begin
            r_chunk <= r_chunk + CHK_W'(1);
          end
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.busy      = w_busy;
  assign bus.out_count = r_count;
endmodule

// File: tb/tb_cmp63_popcount_seq.sv
// Testbench for cmp63_popcount_seq: a 48-bit and a 10-bit instance, directed
// steps with a scoreboard queue of expected counts.
module tb_cmp63_popcount_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCompared = 0;
  int   nMismatch = 0;
  int   expQ[$];

  always #5 clk = ~clk;

  cmp63_popcount_seq_if #(.DATA_W(48)) bus48 ();
  cmp63_popcount_seq_if #(.DATA_W(10)) bus10 ();

  cmp63_popcount_seq #(.DATA_W(48)) dut48 (
    .clk (clk),
    .rst (rst),
    .bus (bus48.slave)
  );

  cmp63_popcount_seq #(.DATA_W(10)) dut10 (
    .clk (clk),
    .rst (rst),
    .bus (bus10.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] getCount(input int dut);
    return (dut == 0) ? 64'(bus48.out_count) : 64'(bus10.out_count);
  endfunction

  function automatic logic getValid(input int dut);
    return (dut == 0) ? bus48.out_valid : bus10.out_valid;
  endfunction

  function automatic logic getInReady(input int dut);
    return (dut == 0) ? bus48.in_ready : bus10.in_ready;
  endfunction

  function automatic logic getBusy(input int dut);
    return (dut == 0) ? bus48.busy : bus10.busy;
  endfunction

  task automatic setOutReady(input int dut, input logic v);
    if (dut == 0) bus48.out_ready = v;
    else          bus10.out_ready = v;
  endtask

  // Present one word for a single edge, record its expected count, then scramble in_data.
  task automatic applyStimulus(input int dut, input logic [47:0] word, input string tag);
    logic [9:0] w10;
    w10 = word[9:0];
    if (dut == 0) begin
      bus48.in_valid = 1'b1;
      bus48.in_data  = word;
    end else begin
      bus10.in_valid = 1'b1;
      bus10.in_data  = w10;
    end
    tick();
    expQ.push_back((dut == 0) ? $countones(word) : $countones(w10));
    bus48.in_valid = 1'b0;
    bus10.in_valid = 1'b0;
    bus48.in_data  = 48'({$urandom(), $urandom()});
    bus10.in_data  = 10'($urandom());
    check({tag, " accepted busy"}, 64'(getBusy(dut)), 64'd1);
  endtask

  task automatic waitValid(input int dut, output int n);
    n = 0;
    while (!getValid(dut) && n < 40) begin
      tick();
      n++;
    end
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then drain.
  task automatic checkOutput(input int dut, input int holdCycles, input string tag);
    int n;
    int nchunk;
    logic [63:0] exp;
    nchunk = (dut == 0) ? 8 : 2;
    setOutReady(dut, holdCycles == 0);
    waitValid(dut, n);
    check({tag, " latency"}, 64'(n), 64'(nchunk));
    exp = (expQ.size() > 0) ? 64'(expQ.pop_front()) : '1;
    check({tag, " count"}, getCount(dut), exp);
    for (int h = 0; h < holdCycles; h++) begin
      tick();
      check({tag, " hold valid"}, 64'(getValid(dut)), 64'd1);
      check({tag, " hold count"}, getCount(dut), exp);
      check({tag, " hold in_ready"}, 64'(getInReady(dut)), 64'd0);
    end
    setOutReady(dut, 1'b1);
    tick();
    check({tag, " idle in_ready"}, 64'(getInReady(dut)), 64'd1);
    check({tag, " idle out_valid"}, 64'(getValid(dut)), 64'd0);
    check({tag, " idle busy"}, 64'(getBusy(dut)), 64'd0);
  endtask

  initial begin
    int n;
    logic [47:0] word;
    bus48.clear = 1'b0; bus48.in_valid = 1'b0; bus48.in_data = '0; bus48.out_ready = 1'b1;
    bus10.clear = 1'b0; bus10.in_valid = 1'b0; bus10.in_data = '0; bus10.out_ready = 1'b1;

    $display("[TB] reset");
    rst = 1'b1;
    tick();
    tick();
    check("reset in_ready", 64'(bus48.in_ready), 64'd1);
    check("reset out_valid", 64'(bus48.out_valid), 64'd0);
    check("reset out_count", 64'(bus48.out_count), 64'd0);
    check("reset busy", 64'(bus48.busy), 64'd0);
    check("reset10 in_ready", 64'(bus10.in_ready), 64'd1);
    rst = 1'b0;
    tick();

    $display("[TB] basic words");
    applyStimulus(0, 48'h0, "zero");
    checkOutput(0, 0, "zero");
    applyStimulus(0, 48'hFFFF_FFFF_FFFF, "ones");
    checkOutput(0, 0, "ones");
    applyStimulus(0, 48'hAAAA_AAAA_AAAA, "stall");
    checkOutput(0, 5, "stall");

    $display("[TB] reset mid-run");
    applyStimulus(0, 48'h0000_0000_003F, "rstmid");
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expQ.delete();
    check("rstmid out_valid", 64'(bus48.out_valid), 64'd0);
    check("rstmid in_ready", 64'(bus48.in_ready), 64'd1);
    check("rstmid busy", 64'(bus48.busy), 64'd0);
    check("rstmid out_count", 64'(bus48.out_count), 64'd0);
    applyStimulus(0, 48'h8000_0000_0001, "resend1");
    checkOutput(0, 0, "resend1");

    $display("[TB] clear handling");
    bus48.clear    = 1'b1;
    bus48.in_valid = 1'b1;
    bus48.in_data  = 48'h0F0F_0F0F_0F0F;
    tick();
    bus48.clear    = 1'b0;
    bus48.in_valid = 1'b0;
    check("clrIdle busy", 64'(bus48.busy), 64'd0);
    check("clrIdle in_ready", 64'(bus48.in_ready), 64'd1);
    check("clrIdle out_count", 64'(bus48.out_count), 64'd0);
    tick();
    check("clrIdle still idle", 64'(bus48.busy), 64'd0);

    applyStimulus(0, 48'h1234_5678_9ABC, "clrDone");
    setOutReady(0, 1'b0);
    waitValid(0, n);
    check("clrDone latency", 64'(n), 64'd8);
    bus48.clear = 1'b1;
    tick();
    bus48.clear = 1'b0;
    expQ.delete();
    check("clrDone out_valid", 64'(bus48.out_valid), 64'd0);
    check("clrDone in_ready", 64'(bus48.in_ready), 64'd1);
    check("clrDone out_count", 64'(bus48.out_count), 64'd0);
    applyStimulus(0, 48'h1234_5678_9ABC, "resend2");
    checkOutput(0, 0, "resend2");

    $display("[TB] random words");
    for (int i = 0; i < 4; i++) begin
      word = 48'({$urandom(), $urandom()});
      applyStimulus(0, word, "rand");
      checkOutput(0, i % 3, "rand");
    end

    $display("[TB] 10-bit instance");
    applyStimulus(1, 48'h3FF, "d10 3FF");
    checkOutput(1, 0, "d10 3FF");
    applyStimulus(1, 48'h201, "d10 201");
    checkOutput(1, 2, "d10 201");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end
endmodule
